// File: rtl/gen_col_if.sv
// gen_col_if
// Bundles the Toeplitz seed inputs and the generated column into one interface.
// Parameters:
//   N  number of matrix columns, which is the width of rrow0
//   L  number of matrix rows, which is the width of col0 and col
// Signals:
//   rrow0  N bits  first matrix row, rrow0[j] = T[0][j]
//   col0   L bits  first matrix column, col0[L-1-i] = T[i][0]
//   col    L bits  current generated column, col[L-1-i] = T[i][cnt]
// Modports:
//   master  seed loader / column consumer: drives rrow0 and col0, reads col
//   slave   column generator: reads rrow0 and col0, drives col
interface gen_col_if #(
    parameter int N = 256,
    parameter int L = 128
);
    logic [N-1:0] rrow0;
    logic [L-1:0] col0;
    logic [L-1:0] col;

    modport master (
        output rrow0,
        output col0,
        input  col
    );

    modport slave (
        input  rrow0,
        input  col0,
        output col
    );
endinterface

// File: rtl/gen_col.sv
// gen_col
// Produces one column of an L x N binary Toeplitz matrix per clock.
// The matrix is fully defined by its first column (col0) and first row (rrow0).
// Several instances that share STRIDE and use distinct INDEX values cover all
// columns between them, each instance walking its own interleaved subset.
// Parameters:
//   BS      seed loader word width; N and L must be multiples of it
//   N       matrix columns, power of two
//   L       matrix rows
//   STRIDE  column step per clock, power of two, 1..L, divides N
//   INDEX   first column produced, 0..STRIDE-1
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    gen_col_if slave: rrow0/col0 seeds in, col out
module gen_col #(
    parameter int BS     = 64,
    parameter int N      = 256,
    parameter int L      = 128,
    parameter int STRIDE = 1,
    parameter int INDEX  = 0
) (
    input  logic      clk,
    input  logic      reset,
    gen_col_if.slave  bus
);
    localparam int CW  = $clog2(N);
    localparam int CW1 = CW + 1;

    // One extra bit so cnt+STRIDE can be compared against N without overflow.
    localparam logic [CW1-1:0] STRIDE_W = CW1'(STRIDE);
    localparam logic [CW1-1:0] N_W      = CW1'(N);
    localparam logic [CW-1:0]  INDEX_W  = CW'(INDEX);

    // Elaboration-time legality checks on the parameter set.
    generate
        if ((N % BS) != 0 || (L % BS) != 0) begin : g_bad_bs
            $error("gen_col: N and L must be multiples of BS");
        end
        if ((N & (N - 1)) != 0) begin : g_bad_n
            $error("gen_col: N must be a power of two");
        end
        if (STRIDE < 1 || STRIDE > L || (STRIDE & (STRIDE - 1)) != 0 || (N % STRIDE) != 0) begin : g_bad_stride
            $error("gen_col: STRIDE must be a power of two in 1..L dividing N");
        end
        if (INDEX < 0 || INDEX >= STRIDE) begin : g_bad_index
            $error("gen_col: INDEX must lie in 0..STRIDE-1");
        end
    endgenerate

    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_d;
    logic [L-1:0]      col_q;
    logic [L-1:0]      col_d;
    logic [L-1:0]      idx_col;
    logic [L-1:0]      shifted;
    logic [CW1-1:0]    cnt_step;
    logic [STRIDE-1:0] new_bits;

    // Column INDEX is a fixed rewiring of the seeds: the top INDEX rows come
    // from rrow0[INDEX..1], everything from the diagonal down is col0 shifted.
    // All indices are constants, so this is wiring only.
    always_comb begin
        idx_col = '0;
        for (int i = 0; i < INDEX; i++) begin
            idx_col[L-1-i] = bus.rrow0[INDEX-i];
        end
        for (int i = INDEX; i < L; i++) begin
            idx_col[L-1-i] = bus.col0[L-1-(i-INDEX)];
        end
    end

    assign cnt_step = {1'b0, cnt} + STRIDE_W;

    // The STRIDE new top bits of the next column are rrow0[cnt+STRIDE .. cnt+1].
    // On a wrap step this select may fall outside rrow0, but its value is
    // discarded there because the index column is loaded instead.
    assign new_bits = bus.rrow0[cnt_step[CW-1:0] -: STRIDE];

    // Moving STRIDE columns right pushes every row down by STRIDE.
    generate
        if (STRIDE < L) begin : g_shift
            assign shifted = {new_bits, col_q[L-1:STRIDE]};
        end else begin : g_replace
            assign shifted = new_bits;
        end
    endgenerate

    always_comb begin
        cnt_d = cnt;
        col_d = col_q;
        if (cnt_step >= N_W) begin
            cnt_d = INDEX_W;
            col_d = idx_col;
        end else begin
            cnt_d = cnt_step[CW-1:0];
            col_d = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= INDEX_W;
            col_q <= idx_col;
        end else begin
            cnt   <= cnt_d;
            col_q <= col_d;
        end
    end

    assign bus.col = col_q;
endmodule

// File: tb/tb_gen_col.sv
// tb_gen_col
// Self-checking bench for gen_col. Instantiates the small hand-worked case
// (L=4, N=8, STRIDE 1 and 2) and seven full-size instances (N=256, L=128)
// covering STRIDE 1, 2 and 4 with every INDEX, all fed from shared random seeds.
// A behavioural model computes T[*][j] straight from the Toeplitz definition
// and the expected cnt as (INDEX + k*STRIDE) mod N after k post-reset edges.
module tb_gen_col;
    logic clk = 1'b0;
    logic reset;

    logic [255:0] big_rrow0;
    logic [127:0] big_col0;
    logic [7:0]   small_rrow0;
    logic [3:0]   small_col0;

    int n_checks = 0;
    int n_errors = 0;
    int k        = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Column j of the full-size matrix, straight from the Toeplitz definition.
    function automatic logic [127:0] big_col(input int j);
        logic [127:0] c;
        for (int i = 0; i < 128; i++) begin
            if (i >= j) c[127-i] = big_col0[127-(i-j)];
            else        c[127-i] = big_rrow0[j-i];
        end
        return c;
    endfunction

    function automatic logic [3:0] small_col(input int j);
        logic [3:0] c;
        for (int i = 0; i < 4; i++) begin
            if (i >= j) c[3-i] = small_col0[3-(i-j)];
            else        c[3-i] = small_rrow0[j-i];
        end
        return c;
    endfunction

    // k counts edges since the last edge that sampled reset high.
    always @(posedge clk) begin
        if (reset) begin
            k       = 0;
            started = 1'b1;
        end else if (started) begin
            k = k + 1;
        end
    end

    // Full-size instances: g=0 S1/I0, g=1..2 S2/I0..1, g=3..6 S4/I0..3.
    for (genvar g = 0; g < 7; g++) begin : g_big
        localparam int ST = (g == 0) ? 1 : ((g < 3) ? 2 : 4);
        localparam int IX = (g == 0) ? 0 : ((g < 3) ? g - 1 : g - 3);

        gen_col_if #(.N(256), .L(128)) bus ();
        assign bus.rrow0 = big_rrow0;
        assign bus.col0  = big_col0;

        gen_col #(.BS(64), .N(256), .L(128), .STRIDE(ST), .INDEX(IX)) u (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        always @(negedge clk) begin
            int c;
            if (started) begin
                c = (IX + k * ST) % 256;
                check_output($sformatf("cnt_s%0d_i%0d_k%0d", ST, IX, k), 128'(u.cnt), 128'(c));
                check_output($sformatf("col_s%0d_i%0d_k%0d", ST, IX, k), bus.col, big_col(c));
            end
        end
    end

    // Hand-case instances: g=0 STRIDE 1, g=1 STRIDE 2, both INDEX 0.
    for (genvar g = 0; g < 2; g++) begin : g_small
        localparam int ST = g + 1;

        gen_col_if #(.N(8), .L(4)) bus ();
        assign bus.rrow0 = small_rrow0;
        assign bus.col0  = small_col0;

        gen_col #(.BS(4), .N(8), .L(4), .STRIDE(ST), .INDEX(0)) u (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        always @(negedge clk) begin
            int c;
            if (started) begin
                c = (k * ST) % 8;
                check_output($sformatf("small_cnt_s%0d_k%0d", ST, k), 128'(u.cnt), 128'(c));
                check_output($sformatf("small_col_s%0d_k%0d", ST, k), 128'(bus.col), 128'(small_col(c)));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] tmp;

        reset       = 1'b1;
        small_rrow0 = 8'b1100_0110;
        small_col0  = 4'b1010;
        for (int w = 0; w < 8; w++) big_rrow0[w*32 +: 32] = $urandom;
        for (int w = 0; w < 4; w++) big_col0[w*32 +: 32]  = $urandom;

        // Pin the model against the hand-worked columns.
        check_output("model_small_col0", 128'(small_col(0)), 128'(4'b1010));
        check_output("model_small_col1", 128'(small_col(1)), 128'(4'b1101));
        check_output("model_small_col2", 128'(small_col(2)), 128'(4'b1110));
        check_output("model_big_col0", big_col(0), big_col0);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        check_output("hand_reset_col", 128'(g_small[0].bus.col), 128'(4'b1010));
        check_output("hand_reset_cnt", 128'(g_small[0].u.cnt), 128'(0));
        check_output("big_reset_col_s1", g_big[0].bus.col, big_col0);

        step(1);
        check_output("hand_k1_col", 128'(g_small[0].bus.col), 128'(4'b1101));
        check_output("hand_k1_cnt", 128'(g_small[0].u.cnt), 128'(1));
        check_output("hand_s2_k1_col", 128'(g_small[1].bus.col), 128'(4'b1110));
        check_output("hand_s2_k1_cnt", 128'(g_small[1].u.cnt), 128'(2));

        step(1);
        check_output("hand_k2_col", 128'(g_small[0].bus.col), 128'(4'b1110));
        check_output("hand_k2_cnt", 128'(g_small[0].u.cnt), 128'(2));

        // STRIDE 4 / INDEX 3 reaches the last column, then wraps to column 3.
        step(61);
        check_output("wrap_pre_cnt", 128'(g_big[6].u.cnt), 128'(255));
        step(1);
        check_output("wrap_post_cnt", 128'(g_big[6].u.cnt), 128'(3));
        check_output("wrap_post_col", g_big[6].bus.col, big_col(3));

        // 299 post-reset edges.
        step(235);
        check_output("k299_cnt_s1", 128'(g_big[0].u.cnt), 128'(43));
        check_output("k299_cnt_s2", 128'(g_big[1].u.cnt), 128'(86));
        check_output("k299_cnt_s2_i1", 128'(g_big[2].u.cnt), 128'(87));
        check_output("k299_cnt_s4", 128'(g_big[3].u.cnt), 128'(172));
        check_output("k299_cnt_s4_i1", 128'(g_big[4].u.cnt), 128'(173));
        check_output("k299_cnt_s4_i2", 128'(g_big[5].u.cnt), 128'(174));
        check_output("k299_cnt_s4_i3", 128'(g_big[6].u.cnt), 128'(175));
        tmp = big_col(86);
        check_output("adjacent_col_87", g_big[2].bus.col, {big_rrow0[87], tmp[127:1]});

        // Reset for one cycle while STRIDE 1 sits at cnt 100.
        step(57);
        check_output("pre_midreset_cnt_s1", 128'(g_big[0].u.cnt), 128'(100));
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_output("midreset_cnt_s1", 128'(g_big[0].u.cnt), 128'(0));
        check_output("midreset_col_s1", g_big[0].bus.col, big_col0);
        check_output("midreset_cnt_s4_i3", 128'(g_big[6].u.cnt), 128'(3));
        check_output("midreset_col_s4_i3", g_big[6].bus.col, big_col(3));
        check_output("midreset_col_s2_i1", g_big[2].bus.col, big_col(1));

        step(20);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
